// File: rtl/mux8_rr_arbiter_pkg.sv
// rtl/mux8_rr_arbiter_pkg.sv - shared constants and state encoding for the 8-way round-robin arbiter
package mux8_rr_arbiter_pkg;

  localparam int NUM_REQ       = 8;
  localparam int SEL_W         = 3;
  localparam int MAX_BURST_MIN = 1;
  localparam int MAX_BURST_MAX = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/mux8_rr_arbiter_mux.sv
// rtl/mux8_rr_arbiter_mux.sv - 8:1 32-bit data mux shared by the producers
module mux8_32 (
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic [31:0] in3,
  input  logic [31:0] in4,
  input  logic [31:0] in5,
  input  logic [31:0] in6,
  input  logic [31:0] in7,
  input  logic [31:0] in8,
  input  logic [2:0]  sel,
  output logic [31:0] out
);

  // Plain select; in1 corresponds to sel=0.
  always_comb begin
    out = in1;
    case (sel)
      3'd0: out = in1;
      3'd1: out = in2;
      3'd2: out = in3;
      3'd3: out = in4;
      3'd4: out = in5;
      3'd5: out = in6;
      3'd6: out = in7;
      3'd7: out = in8;
      default: out = in1;
    endcase
  end

endmodule

// File: rtl/mux8_rr_arbiter_pick.sv
// rtl/mux8_rr_arbiter_pick.sv - combinational round-robin winner search over 8 requests
module rr_pick8
  import mux8_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   grant_idx,
  output logic               any_req
);

  logic [SEL_W-1:0] idx;
  logic             found;

  // First set request bit at or after ptr, wrapping 7 -> 0.
  always_comb begin
    grant_idx = ptr;
    any_req   = |req;
    found     = 1'b0;
    idx       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ptr + SEL_W'(i);
      if (!found && req[idx]) begin
        grant_idx = idx;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// rtl/mux8_rr_arbiter.sv - round-robin arbiter with bounded bursts driving the shared 8:1 result mux
module mux8_rr_arbiter
  import mux8_rr_arbiter_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        last,
  input  logic [NUM_REQ*DATA_W-1:0] in_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic                      busy
);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("mux8_rr_arbiter: DATA_W must be 32");
  end
  if (MAX_BURST < MAX_BURST_MIN || MAX_BURST > MAX_BURST_MAX) begin : g_bad_burst
    $error("mux8_rr_arbiter: MAX_BURST out of range");
  end
  if ((2 ** CNT_W) < MAX_BURST) begin : g_bad_cnt_w
    $error("mux8_rr_arbiter: CNT_W too narrow for MAX_BURST");
  end

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic [SEL_W-1:0]  pick_idx;
  logic              pick_any;
  logic              xfer;
  logic [DATA_W-1:0] mux_out;

  rr_pick8 u_pick (
    .req       (req),
    .ptr       (rr_ptr_q),
    .grant_idx (pick_idx),
    .any_req   (pick_any)
  );

  mux8_32 u_mux (
    .in1 (in_data[0*DATA_W +: DATA_W]),
    .in2 (in_data[1*DATA_W +: DATA_W]),
    .in3 (in_data[2*DATA_W +: DATA_W]),
    .in4 (in_data[3*DATA_W +: DATA_W]),
    .in5 (in_data[4*DATA_W +: DATA_W]),
    .in6 (in_data[5*DATA_W +: DATA_W]),
    .in7 (in_data[6*DATA_W +: DATA_W]),
    .in8 (in_data[7*DATA_W +: DATA_W]),
    .sel (sel_q),
    .out (mux_out)
  );

  assign busy      = (state_q == GRANT);
  assign out_valid = busy && req[sel_q];
  assign xfer      = out_valid && out_ready;
  assign out_sel   = sel_q;
  assign out_data  = out_valid ? mux_out : '0;

  // One-hot accept pulse toward the granted producer.
  always_comb begin
    ack = '0;
    if (xfer) begin
      ack[sel_q] = 1'b1;
    end
  end

  // Arbitration in IDLE; beat counting and grant release in GRANT.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          sel_d      = pick_idx;
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (xfer) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (last[sel_q] || beat_cnt_q == CNT_W'(MAX_BURST - 1)) begin
            state_d  = IDLE;
            rr_ptr_d = sel_q + SEL_W'(1);
          end
        end else if (!req[sel_q]) begin
          // Producer withdrew before its beat was taken: give up the path.
          state_d  = IDLE;
          rr_ptr_d = sel_q + SEL_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb/tb_mux8_rr_arbiter.sv - self-checking bench for mux8_rr_arbiter
module tb_mux8_rr_arbiter;

  logic         clk;
  logic         rst_n;
  logic [7:0]   req;
  logic [7:0]   last;
  logic [255:0] in_data;
  logic [7:0]   ack;
  logic [2:0]   out_sel;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         busy;

  int errors;
  int checks;

  mux8_rr_arbiter #(
    .DATA_W    (32),
    .MAX_BURST (4),
    .CNT_W     (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .last      (last),
    .in_data   (in_data),
    .ack       (ack),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic [7:0] last;
    logic       rdy;
    logic       v;
    logic [2:0] sel;
    logic [7:0] ack;
    logic       b;
  } vec_t;

  vec_t tbl[19];

  function automatic logic [31:0] slice_val(input int i);
    if (i == 2) return 32'hDEADBEEF;
    return 32'hA5A5_0000 | 32'(i);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst_n     = 1'b0;
    req       = '0;
    last      = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) in_data[32*i +: 32] = slice_val(i);

    // Round robin between 0 and 7 with a bubble between grants.
    tbl[0]  = '{8'h81, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0};
    tbl[1]  = '{8'h81, 8'hFF, 1'b1, 1'b1, 3'd0, 8'h01, 1'b1};
    tbl[2]  = '{8'h81, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0};
    tbl[3]  = '{8'h81, 8'hFF, 1'b1, 1'b1, 3'd7, 8'h80, 1'b1};
    tbl[4]  = '{8'h81, 8'hFF, 1'b1, 1'b0, 3'd7, 8'h00, 1'b0};
    tbl[5]  = '{8'h81, 8'hFF, 1'b1, 1'b1, 3'd0, 8'h01, 1'b1};
    tbl[6]  = '{8'h81, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0};
    tbl[7]  = '{8'h81, 8'hFF, 1'b1, 1'b1, 3'd7, 8'h80, 1'b1};
    // Single request from requester 2.
    tbl[8]  = '{8'h04, 8'h04, 1'b1, 1'b0, 3'd7, 8'h00, 1'b0};
    tbl[9]  = '{8'h04, 8'h04, 1'b1, 1'b1, 3'd2, 8'h04, 1'b1};
    tbl[10] = '{8'h00, 8'h00, 1'b1, 1'b0, 3'd2, 8'h00, 1'b0};
    // Burst cap: pointer is 3, so 0 wins; four beats then release to 1.
    tbl[11] = '{8'h03, 8'h00, 1'b1, 1'b0, 3'd2, 8'h00, 1'b0};
    tbl[12] = '{8'h03, 8'h00, 1'b1, 1'b1, 3'd0, 8'h01, 1'b1};
    tbl[13] = '{8'h03, 8'h00, 1'b1, 1'b1, 3'd0, 8'h01, 1'b1};
    tbl[14] = '{8'h03, 8'h00, 1'b1, 1'b1, 3'd0, 8'h01, 1'b1};
    tbl[15] = '{8'h03, 8'h00, 1'b1, 1'b1, 3'd0, 8'h01, 1'b1};
    tbl[16] = '{8'h03, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0};
    tbl[17] = '{8'h02, 8'h02, 1'b1, 1'b1, 3'd1, 8'h02, 1'b1};
    tbl[18] = '{8'h00, 8'h00, 1'b1, 1'b0, 3'd1, 8'h00, 1'b0};

    // Reset state, then ten idle cycles with no requests.
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset ack", 32'(ack), 32'd0);
    chk("reset out_sel", 32'(out_sel), 32'd0);
    chk("reset out_data", out_data, 32'd0);
    rst_n = 1'b1;
    next_cycle();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("idle%0d out_valid", c), 32'(out_valid), 32'd0);
      chk($sformatf("idle%0d ack", c), 32'(ack), 32'd0);
      chk($sformatf("idle%0d busy", c), 32'(busy), 32'd0);
      chk($sformatf("idle%0d out_sel", c), 32'(out_sel), 32'd0);
      next_cycle();
    end

    for (int r = 0; r < 19; r++) begin
      req       = tbl[r].req;
      last      = tbl[r].last;
      out_ready = tbl[r].rdy;
      @(negedge clk);
      chk($sformatf("row%0d out_valid", r), 32'(out_valid), 32'(tbl[r].v));
      chk($sformatf("row%0d out_sel", r), 32'(out_sel), 32'(tbl[r].sel));
      chk($sformatf("row%0d ack", r), 32'(ack), 32'(tbl[r].ack));
      chk($sformatf("row%0d busy", r), 32'(busy), 32'(tbl[r].b));
      chk($sformatf("row%0d out_data", r), out_data,
          tbl[r].v ? slice_val(int'(tbl[r].sel)) : 32'd0);
      next_cycle();
    end

    // Backpressure: requester 3 granted, consumer stalls five cycles.
    req = 8'h08; last = 8'h08; out_ready = 1'b0;
    @(negedge clk);
    chk("bp idle busy", 32'(busy), 32'd0);
    next_cycle();
    for (int c = 0; c < 5; c++) begin
      req = (c == 2) ? 8'h0F : 8'h08;
      @(negedge clk);
      chk($sformatf("bp%0d out_valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d out_sel", c), 32'(out_sel), 32'd3);
      chk($sformatf("bp%0d out_data", c), out_data, slice_val(3));
      chk($sformatf("bp%0d ack", c), 32'(ack), 32'd0);
      next_cycle();
    end
    req = 8'h08; out_ready = 1'b1;
    @(negedge clk);
    chk("bp release ack", 32'(ack), 32'h08);
    next_cycle();
    req = 8'h00; out_ready = 1'b0;
    @(negedge clk);
    chk("bp after ack", 32'(ack), 32'd0);
    chk("bp after busy", 32'(busy), 32'd0);
    next_cycle();

    // Abandon: requester 5 takes one beat then withdraws.
    req = 8'h20; last = 8'h00; out_ready = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("ab first ack", 32'(ack), 32'h20);
    next_cycle();
    req = 8'h00;
    @(negedge clk);
    chk("ab drop valid", 32'(out_valid), 32'd0);
    chk("ab drop ack", 32'(ack), 32'd0);
    chk("ab drop busy", 32'(busy), 32'd1);
    next_cycle();
    @(negedge clk);
    chk("ab idle busy", 32'(busy), 32'd0);
    chk("ab idle ack", 32'(ack), 32'd0);

    // Asynchronous reset in the middle of a grant.
    req = 8'h20; out_ready = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("ar pre busy", 32'(busy), 32'd1);
    chk("ar pre valid", 32'(out_valid), 32'd1);
    chk("ar pre sel", 32'(out_sel), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar valid", 32'(out_valid), 32'd0);
    chk("ar busy", 32'(busy), 32'd0);
    chk("ar ack", 32'(ack), 32'd0);
    chk("ar out_sel", 32'(out_sel), 32'd0);
    chk("ar out_data", out_data, 32'd0);
    req = 8'h00;
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter that shares one 32-bit result path between 8 requesters.
- Drives the 3-bit select of the team's existing 8:1 32-bit mux and runs a valid/ready handshake toward the single consumer.
- Supports bounded bursts: a granted requester keeps the path for up to MAX_BURST beats, then the grant rotates.
- Sits between the 8 producer units and the shared result/writeback bus.

Parameters:
- DATA_W, 32, data width; only 32 is supported because the data path is the existing 8:1 32-bit mux.
- MAX_BURST, 4, maximum beats per grant; legal range 1..16.
- CNT_W, 4, beat counter width; must satisfy 2**CNT_W >= MAX_BURST.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  8  request per requester; bit i = requester i.
- last  in  8  last[i] marks requester i's current beat as the final beat of its burst.
- in_data  in  256  packed data; requester i occupies bits [32*i+31 : 32*i].
- ack  out  8  one-hot pulse: beat from requester i accepted this cycle.
- out_sel  out  3  registered select code driving the 8:1 mux.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the beat this cycle.
- out_data  out  32  selected data.
- busy  out  1  high while a grant is held (state GRANT).

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out_sel=0, rr_ptr=0, beat_cnt=0. Outputs out_valid=0, ack=0, busy=0, out_data=0. Reset mid-burst abandons the transfer; no ack is issued.
- State IDLE:
  - If req != 0, pick the first set bit scanning from rr_ptr upward, wrapping 7->0.
  - Register the winner into out_sel, clear beat_cnt, go to GRANT.
  - If req == 0, stay in IDLE.
  - Latency: req asserted in cycle N gives out_valid in cycle N+1, at the earliest.
- State GRANT (busy=1):
  - out_valid = req[out_sel], combinational.
  - out_data = in_data slice selected by out_sel when out_valid=1, else 0.
  - A transfer occurs when out_valid && out_ready. In that cycle ack[out_sel]=1, all other ack bits 0, and beat_cnt increments.
  - Release the grant (go to IDLE, rr_ptr <= out_sel+1 mod 8) when either:
    - a transfer occurs with last[out_sel]=1 or beat_cnt==MAX_BURST-1, or
    - req[out_sel] drops without a transfer (abandon; no ack).
  - Otherwise stay in GRANT. A stalled consumer (out_ready=0) holds the state indefinitely; out_sel and beat_cnt are unchanged.
- Every grant release costs one IDLE arbitration bubble cycle. This is intentional for timing.
- Requester contract: hold in_data slice and last stable while req is high and ack is not yet seen. A requester may re-assert req in the cycle after its ack.
- Simultaneous requests: only the round-robin winner is served; losers keep req high and are not acked.
- Changes on non-granted req bits while in GRANT are ignored.
- Wrap-around: rr_ptr after grant 7 is 0.
- MAX_BURST=1: every transfer releases the grant.
- ack is never asserted in IDLE. At most one ack bit is set in any cycle.

Decomposition:
- Shared package holds:
  - NUM_REQ=8 and SEL_W=3.
  - State encoding: IDLE=1'b0, GRANT=1'b1.
  - MAX_BURST range limits.
- Sub-module rr_pick8 (combinational): inputs req[7:0] and ptr[2:0]; outputs grant_idx[2:0] and any_req.
- Data selection: instantiate the existing 8:1 32-bit mux with in1..in8 = slices 0..7 and selection = out_sel. out_data is then gated with out_valid.

Test Plan:
- Reset/idle: rst_n=0, then release with req=0 -> out_valid=0, ack=0, busy=0, out_sel=0 for 10 cycles.
- Single request: req=8'h04, slice2=32'hDEADBEEF, last[2]=1, out_ready=1 -> cycle+1 shows out_sel=2, out_valid=1, out_data=DEADBEEF, ack=8'h04; then IDLE with rr_ptr=3.
- Round-robin and wrap: req=8'h81 held with last=8'hFF -> grants in order 0,7,0,7 with one bubble cycle between each.
- Burst cap: MAX_BURST=4, req=8'h03 held, last=0, out_ready=1 -> requester 0 receives exactly 4 acks, then requester 1 is granted.
- Backpressure: in GRANT, out_ready=0 for 5 cycles -> out_valid=1, out_data stable, ack=0. When out_ready goes to 1 -> exactly one ack.
- Abandon and async reset: drop req[out_sel] mid-burst -> IDLE next cycle with no ack. Assert rst_n=0 mid-GRANT -> out_valid and busy fall immediately (asynchronously).
